// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: streams one layer's weights from an upstream valid/ready source into weight memory.
// Writes are registered one cycle after acceptance, so the final write lands during DRAIN.
module weight_load_ctrl #(
    parameter int L1_NUM = 216,
    parameter int L8_NUM = 576,
    parameter int L7_NUM = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  layer_id,
    input  logic        abort,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        write_weight_signal,
    output logic [15:0] write_weight_data,
    output logic [15:0] write_weight_addr,
    output logic [3:0]  weight_fsm_cs,
    output logic        weight_store_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, STORE, DRAIN, FINISH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  code_q, code_d, cs_q, cs_d, new_code;
    logic [15:0] n_q, n_d, cnt_q, cnt_d, data_q, addr_q, new_n;
    logic        wr_q, done_q, accept;

    always_comb begin
        new_code = layer_id == 3'd1 ? 4'd1 :
                   layer_id == 3'd2 ? 4'd2 :
                   layer_id == 3'd4 ? 4'd3 :
                   layer_id == 3'd5 ? 4'd4 :
                   layer_id == 3'd7 ? 4'd5 : 4'd0;
        new_n = layer_id == 3'd1 ? 16'(L1_NUM) : layer_id == 3'd7 ? 16'(L7_NUM) : 16'(L8_NUM);
        // abort outranks a coincident beat so a cancelled load never writes
        accept = src_valid && state_q == STORE && !abort;
        state_d = state_q;
        code_d = code_q;
        n_d = n_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (start && new_code != 4'd0) begin
                state_d = STORE;
                code_d = new_code;
                n_d = new_n;
                cnt_d = 16'd0;
            end
            STORE: if (abort) begin
                state_d = IDLE;
                cnt_d = 16'd0;
            end else if (accept) begin
                cnt_d = cnt_q + 16'd1;
                state_d = cnt_q == n_q - 16'd1 ? DRAIN : STORE;
            end
            DRAIN: begin
                state_d = abort ? IDLE : FINISH;
                cnt_d = abort ? 16'd0 : cnt_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d = 16'd0;
            end
        endcase
        cs_d = state_d == IDLE ? 4'b0000 : state_d == FINISH ? 4'b1111 : code_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q <= 4'd0;
            n_q <= 16'd0;
            cnt_q <= 16'd0;
            wr_q <= 1'b0;
            data_q <= 16'd0;
            addr_q <= 16'd0;
            cs_q <= 4'd0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q <= code_d;
            n_q <= n_d;
            cnt_q <= cnt_d;
            wr_q <= accept;
            data_q <= accept ? src_data : data_q;
            addr_q <= accept ? cnt_q : addr_q;
            cs_q <= cs_d;
            done_q <= state_d == FINISH;
        end
    end

    assign src_ready = state_q == STORE;
    assign busy = state_q != IDLE;
    assign write_weight_signal = wr_q;
    assign write_weight_data = data_q;
    assign write_weight_addr = addr_q;
    assign weight_fsm_cs = cs_q;
    assign weight_store_done = done_q;
endmodule
